// File: rtl/fe_types.sv
// Shared field-element types and constants for arithmetic modulo p = 2^255-19.
// Latency: none; types, constants and helpers only.
// Backpressure: not applicable.
package fe_types;

  // Field element as 4x64-bit limbs flattened; limb 0 occupies bits [63:0].
  typedef logic [255:0] fe_t;

  // Extended twisted-Edwards point; T is carried but never used by the encoder.
  typedef struct packed {
    fe_t t;
    fe_t z;
    fe_t y;
    fe_t x;
  } point_ext_t;

  localparam fe_t P_CONST   = (256'd1 << 255) - 256'd19;
  // Fermat inversion exponent; bit 254 is 1 and seeds the accumulator.
  localparam fe_t P_MINUS_2 = (256'd1 << 255) - 256'd21;

  localparam logic [7:0] EXP_TOP_BIT = 8'd253;

  // Encoder FSM encodings.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_INV_SQR = 3'd2;
  localparam logic [2:0] ST_INV_MUL = 3'd3;
  localparam logic [2:0] ST_MUL_X   = 3'd4;
  localparam logic [2:0] ST_MUL_Y   = 3'd5;
  localparam logic [2:0] ST_CANON   = 3'd6;
  localparam logic [2:0] ST_OUT     = 3'd7;

  // Reduce a value known to be < 2p into [0,p) with one conditional subtraction.
  function automatic fe_t fe_canon(input fe_t v);
    return (v >= P_CONST) ? (v - P_CONST) : v;
  endfunction

endpackage

// File: rtl/fe_mul_seq.sv
// Modular multiplier r = a*b mod p (result < 2p, not canonical).
// Latency: done pulses exactly MUL_LAT cycles after the start cycle (MUL_LAT 1..15).
// Backpressure: none; caller issues a new start only after done, reset aborts.
module fe_mul_seq
  import fe_types::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  fe_t  a,
  input  fe_t  b,
  output logic done,
  output fe_t  r
);

  localparam int CW = 4;

  logic [CW-1:0] cnt;
  fe_t           a_q;
  fe_t           b_q;
  logic [511:0]  prod;
  logic [262:0]  fold1;
  logic [255:0]  fold2;

  // Latch operands on start and count down the fixed latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      a_q <= '0;
      b_q <= '0;
    end else if (start) begin
      cnt <= CW'(MUL_LAT);
      a_q <= a;
      b_q <= b;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == CW'(1));

  // Product and two folds: 2^256 == 38 and 2^255 == 19 (mod p); result < 2^255 + 4845 < 2p.
  always_comb begin
    prod  = {256'd0, a_q} * {256'd0, b_q};
    fold1 = {7'd0, prod[255:0]} + {7'd0, prod[511:256]} * 263'd38;
    fold2 = {1'b0, fold1[254:0]} + {248'd0, fold1[262:255]} * 256'd19;
  end

  assign r = fold2;

endmodule

// File: rtl/point_encode.sv
// Encodes an extended Edwards point to its 32-byte RFC 8032 form via Fermat inversion of Z.
// Latency: out_valid rises 508*(MUL_LAT+1)+3 cycles after acceptance, independent of data.
// Backpressure: in_ready only in IDLE; result held stable in OUT until out_ready.
module point_encode
  import fe_types::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  point_ext_t   point_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] enc_out,
  output logic         err_out
);

  logic [2:0] state;
  logic [7:0] bit_idx;
  logic       busy;
  fe_t        x_q;
  fe_t        y_q;
  fe_t        z_q;
  fe_t        acc;
  fe_t        xr;
  fe_t        yr;

  logic       mul_state;
  logic       mul_start;
  logic       mul_done;
  fe_t        mul_a;
  fe_t        mul_b;
  fe_t        mul_r;

  fe_t        y_c;
  fe_t        zi_c;
  logic       x_par;
  logic       zi_zero;

  // T is not needed for the encoding.
  logic       unused_t;
  assign unused_t = ^point_in.t;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_OUT);

  assign mul_state = (state == ST_INV_SQR) || (state == ST_INV_MUL) ||
                     (state == ST_MUL_X)   || (state == ST_MUL_Y);
  // One start pulse on the first cycle of each multiply state.
  assign mul_start = mul_state && !busy;

  // Select multiplier operands for the current step of the schedule.
  always_comb begin
    mul_a = acc;
    mul_b = acc;
    case (state)
      ST_INV_MUL: mul_b = z_q;
      ST_MUL_X:   mul_a = x_q;
      ST_MUL_Y:   mul_a = y_q;
      default:    ;
    endcase
  end

  fe_mul_seq #(.MUL_LAT(MUL_LAT)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (mul_a),
    .b     (mul_b),
    .done  (mul_done),
    .r     (mul_r)
  );

  // Canonical forms; since p is odd, canonical x parity flips exactly when x >= p.
  always_comb begin
    y_c     = fe_canon(yr);
    zi_c    = fe_canon(acc);
    x_par   = xr[0] ^ (xr >= P_CONST);
    zi_zero = (zi_c == '0);
  end

  // Sequencer: capture, fixed square-and-multiply inversion, scale, canonicalise, hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bit_idx <= EXP_TOP_BIT;
      busy    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      acc     <= '0;
      xr      <= '0;
      yr      <= '0;
      enc_out <= '0;
      err_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            x_q   <= point_in.x;
            y_q   <= point_in.y;
            z_q   <= point_in.z;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          acc     <= z_q;
          bit_idx <= EXP_TOP_BIT;
          busy    <= 1'b0;
          state   <= ST_INV_SQR;
        end
        ST_INV_SQR: begin
          if (!busy) begin
            busy <= 1'b1;
          end else if (mul_done) begin
            busy <= 1'b0;
            acc  <= mul_r;
            if (P_MINUS_2[bit_idx]) begin
              state <= ST_INV_MUL;
            end else if (bit_idx == 8'd0) begin
              state <= ST_MUL_X;
            end else begin
              bit_idx <= bit_idx - 8'd1;
            end
          end
        end
        ST_INV_MUL: begin
          if (!busy) begin
            busy <= 1'b1;
          end else if (mul_done) begin
            busy <= 1'b0;
            acc  <= mul_r;
            if (bit_idx == 8'd0) begin
              state <= ST_MUL_X;
            end else begin
              bit_idx <= bit_idx - 8'd1;
              state   <= ST_INV_SQR;
            end
          end
        end
        ST_MUL_X: begin
          if (!busy) begin
            busy <= 1'b1;
          end else if (mul_done) begin
            busy  <= 1'b0;
            xr    <= mul_r;
            state <= ST_MUL_Y;
          end
        end
        ST_MUL_Y: begin
          if (!busy) begin
            busy <= 1'b1;
          end else if (mul_done) begin
            busy  <= 1'b0;
            yr    <= mul_r;
            state <= ST_CANON;
          end
        end
        ST_CANON: begin
          err_out <= zi_zero;
          enc_out <= zi_zero ? '0 : ({x_par, 255'd0} | y_c);
          state   <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_point_encode.sv
// Directed bench for point_encode with a queue of expected encodings.
module tb_point_encode;
  import fe_types::*;

  localparam int MUL_LAT = 4;
  localparam int LAT     = 508 * (MUL_LAT + 1) + 3;

  localparam logic [255:0] P_TB   = (256'd1 << 255) - 256'd19;
  localparam logic [255:0] BX     = 256'h216936D3CD6E53FE_C0A4E231FDD6DC5C_692CC7609525A7B2_C9562D608F25D51A;
  localparam logic [255:0] BY     = 256'h6666666666666666_6666666666666666_6666666666666666_6666666666666658;
  localparam logic [255:0] ENC_B  = 256'h6666666666666666_6666666666666666_6666666666666666_6666666666666658;
  localparam logic [255:0] ENC_NB = 256'hE666666666666666_6666666666666666_6666666666666666_6666666666666658;
  localparam logic [255:0] T_JUNK = 256'hDEADBEEF_CAFEF00D_01234567_89ABCDEF_DEADBEEF_CAFEF00D_01234567_89ABCDEF;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  point_ext_t   point_in;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] enc_out;
  logic         err_out;

  int cyc    = 0;
  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [255:0] enc;
    logic         err;
    int           due;
  } exp_t;

  exp_t sb[$];

  point_encode #(.MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .point_in  (point_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .enc_out   (enc_out),
    .err_out   (err_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic point_ext_t mk(input logic [255:0] x, input logic [255:0] y, input logic [255:0] z);
    point_ext_t p;
    p.x = x;
    p.y = y;
    p.z = z;
    p.t = T_JUNK;
    return p;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting cycle.
  task automatic send(input point_ext_t pt, input logic [255:0] enc, input logic err);
    exp_t e;
    int   k;
    in_valid = 1'b1;
    point_in = pt;
    k = 0;
    while (!in_ready && k < 2 * LAT) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) check("accept_timeout", 256'(in_ready), 256'd1);
    e.enc = enc;
    e.err = err;
    e.due = cyc + LAT;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    point_in = '1;
    check("busy_in_ready", 256'(in_ready), 256'd0);
  endtask

  // Waits for the next result; with hold>0 keeps out_ready low and leaves the result pending.
  task automatic wait_result(input int hold, input string tag);
    exp_t         e;
    int           k;
    logic [255:0] enc_s;
    e = sb.pop_front();
    out_ready = (hold == 0);
    k = 0;
    while (!out_valid && k < LAT + 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, ".latency"}, 256'(cyc), 256'(e.due));
    check({tag, ".enc"}, enc_out, e.enc);
    check({tag, ".err"}, 256'(err_out), 256'(e.err));
    if (hold == 0) begin
      @(negedge clk);
      check({tag, ".consumed"}, 256'(out_valid), 256'd0);
    end else begin
      enc_s = enc_out;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, ".hold_valid"}, 256'(out_valid), 256'd1);
        check({tag, ".hold_enc"}, enc_out, enc_s);
        check({tag, ".hold_in_ready"}, 256'(in_ready), 256'd0);
      end
    end
  endtask

  initial begin
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    point_in  = '0;
    repeat (3) @(negedge clk);
    check("rst.out_valid", 256'(out_valid), 256'd0);
    check("rst.enc", enc_out, 256'd0);
    check("rst.err", 256'(err_out), 256'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.in_ready", 256'(in_ready), 256'd1);

    send(mk(BX, BY, 256'd1), ENC_B, 1'b0);
    wait_result(0, "base");

    send(mk(256'd0, 256'd1, 256'd1), 256'd1, 1'b0);
    wait_result(0, "identity");

    send(mk(BX << 1, BY << 1, 256'd2), ENC_B, 1'b0);
    wait_result(0, "base_z2");

    send(mk(256'd0, P_TB + 256'd1, 256'd1), 256'd1, 1'b0);
    wait_result(0, "y_p_plus_1");

    send(mk(BX, BY, 256'd0), 256'd0, 1'b1);
    wait_result(0, "z_zero");

    send(mk(BX, BY, P_TB), 256'd0, 1'b1);
    wait_result(0, "z_eq_p");

    // Negated base point: odd x sets bit 255; then backpressure plus offer during OUT.
    send(mk(P_TB - BX, BY, 256'd1), ENC_NB, 1'b0);
    wait_result(10, "neg_bp");
    in_valid  = 1'b1;
    point_in  = mk(256'd0, 256'd1, 256'd1);
    out_ready = 1'b1;
    check("bp.no_accept_in_out", 256'(in_ready), 256'd0);
    @(negedge clk);
    check("bp.out_dropped", 256'(out_valid), 256'd0);
    check("bp.ready_next", 256'(in_ready), 256'd1);
    send(mk(256'd0, 256'd1, 256'd1), 256'd1, 1'b0);
    wait_result(0, "after_bp");

    // Abort mid-inversion: no output may appear for the aborted point.
    send(mk(BX, BY, 256'd1), ENC_B, 1'b0);
    void'(sb.pop_back());
    repeat (998) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort.in_ready", 256'(in_ready), 256'd1);
    check("abort.enc_cleared", enc_out, 256'd0);
    seen = 0;
    for (int i = 0; i < LAT + 20; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort.no_output", 256'(seen), 256'd0);
    send(mk(BX << 1, BY << 1, 256'd2), ENC_B, 1'b0);
    wait_result(0, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
